picorv32_mem_adapter: RTL
=========================

// Module: picorv32_mem_adapter
// PURPOSE
// Memory front-end directly below picorv32_core: arbitrates the core's 32-bit port and the
// 128-bit external (DTU/NoC) port onto one single-port 128-bit SRAM with 1-cycle read latency.
// Drives the core's mem_stall_i/mem_rdata_i so the core's contract holds: read data is valid
// the cycle after an unstalled request. Also does lane select/replication and out-of-range errors.
// PARAMETERS
// PICO_MEM_ADDR_SIZE  32        byte-address width, both request ports
// ASM_MEM_DATA_SIZE   128       SRAM/ext data width; fixed at 128 (4 x 32-bit lanes)
// SRAM_ADDR_SIZE      12        SRAM word-address width (word = 16 B)
// MEM_SIZE_BYTES      'h10000   mapped bytes; addr >= MEM_SIZE_BYTES is out of range
// STARVE_LIMIT        4         consecutive pico stall cycles before forced grant (PICO_MEM_ARB_FAIR_EN)
// PORTS
// clk_i          in   1    clock
// resetn_i       in   1    async active-low reset
// pico_en_i      in   1    core request valid (mem_en_o)
// pico_we_i      in   4    core byte write enables; 0 = read
// pico_addr_i    in   32   core byte address
// pico_wdata_i   in   32   core write data
// pico_rdata_o   out  32   core read data (to mem_rdata_i)
// pico_stall_o   out  1    core stall, combinational (to mem_stall_i)
// ext_en_i       in   1    ext request valid
// ext_we_i       in   16   ext byte write enables; 0 = read
// ext_addr_i     in   32   ext byte address, 16-B aligned (addr[3:0] ignored)
// ext_wdata_i    in   128  ext write data
// ext_rdata_o    out  128  ext read data
// ext_rvalid_o   out  1    ext read data valid pulse
// ext_stall_o    out  1    ext stall, combinational
// sram_en_o      out  1    SRAM access enable
// sram_we_o      out  16   SRAM byte write enables
// sram_addr_o    out  12   SRAM word address = addr[SRAM_ADDR_SIZE+3:4]
// sram_wdata_o   out  128  SRAM write data
// sram_rdata_i   in   128  SRAM read data, valid 1 cycle after sram_en_o with sram_we_o=0
// err_o          out  1    1-cycle pulse on accepted out-of-range access (either port)
// BEHAVIOUR
// - Reset: pico_rdata_o=0, ext_rdata_o=0, ext_rvalid_o=0, err_o=0, starve count=0, no read in flight;
//   sram_*_o and stalls are combinational from inputs (0 when both en low). Reset mid-read discards it.
// - Accept: port accepted when en=1 and stall=0. Exactly one port granted per cycle.
// - Arbitration: both en -> ext granted, pico_stall_o=1. Lone requester never stalls.
// - Out-of-range accept: no SRAM access; err_o=1 next cycle; read returns 0 with normal latency.
// - Pico write: sram_we_o = pico_we_i << 4*addr[3:2]; sram_wdata_o = {4{pico_wdata_i}}.
// - Pico read: lane addr[3:2] registered; cycle N+1 pico_rdata_o = lane of sram_rdata_i and
//   captured in hold reg; pico_rdata_o = hold reg until next accepted pico read.
// - Repeated pico accepts of same request (core holds en through ready cycle) are legal:
//   writes re-issued (idempotent), reads re-read; no special casing.
// - Ext read: accept at N -> ext_rvalid_o=1, ext_rdata_o=sram_rdata_i at N+1; ext_rdata_o held after.
// - Ext write: passes we/wdata unchanged; no rvalid. Pipelined back-to-back accepts, 1/cycle/port.
// - In-flight read tracked by 1-bit owner reg; one cycle max, so no FIFO.
// CONFIGURATION
// - PICO_MEM_ARB_FAIR_EN defined: counter increments each cycle pico_en_i=1 & pico_stall_o=1;
//   when count==STARVE_LIMIT, pico granted next cycle even if ext_en_i=1 (ext stalled);
//   counter clears on pico accept or pico_en_i=0. Worst-case pico wait = STARVE_LIMIT cycles.
// - Undefined: strict ext priority, no counter; pico may starve indefinitely.
// TESTING
// - Pico write addr 'h24 we=4'b1111 data 'hDEADBEEF -> sram_we_o='h00F0, sram_addr_o=2, lane1 data.
// - Pico read 'h24 after above -> pico_rdata_o='hDEADBEEF 1 cycle after accept, held 5 idle cycles.
// - Ext read 'h20 and pico read 'h30 same cycle -> ext accepted, pico_stall_o=1 one cycle,
//   ext_rvalid_o next cycle, pico accepted next cycle, data 1 cycle later.
// - Ext en held 10 cycles, pico en held: FAIR_EN -> pico granted after exactly 4 stall cycles;
//   without -> pico stalled all 10.
// - Pico read 'h10000 -> no sram_en_o, err_o pulse, pico_rdata_o=0 next cycle.
// - resetn_i low in cycle after ext read accept -> ext_rvalid_o stays 0, all outputs reset values.

Source files
------------

// File: rtl/picorv32_mem_adapter.sv
// picorv32_mem_adapter
// Memory front-end below picorv32_core. Arbitrates the 32-bit core port and the
// 128-bit external port onto one single-port 128-bit SRAM with 1-cycle read latency.
// It also handles lane select and replication, and flags out-of-range accesses.
// Optional feature: define PICO_MEM_ARB_FAIR_EN to bound core starvation.
// With the macro defined, the core is force-granted after STARVE_LIMIT stall cycles.
// Without it, the external port has strict priority.
module picorv32_mem_adapter #(
   parameter int unsigned                   PICO_MEM_ADDR_SIZE = 32,
   parameter int unsigned                   ASM_MEM_DATA_SIZE  = 128,
   parameter int unsigned                   SRAM_ADDR_SIZE     = 12,
   parameter logic [PICO_MEM_ADDR_SIZE-1:0] MEM_SIZE_BYTES     = 32'h0001_0000,
   parameter int unsigned                   STARVE_LIMIT       = 4
) (
   input  logic                            clk_i,
   input  logic                            resetn_i,
   input  logic                            pico_en_i,
   input  logic [3:0]                      pico_we_i,
   input  logic [PICO_MEM_ADDR_SIZE-1:0]   pico_addr_i,
   input  logic [31:0]                     pico_wdata_i,
   output logic [31:0]                     pico_rdata_o,
   output logic                            pico_stall_o,
   input  logic                            ext_en_i,
   input  logic [ASM_MEM_DATA_SIZE/8-1:0]  ext_we_i,
   input  logic [PICO_MEM_ADDR_SIZE-1:0]   ext_addr_i,
   input  logic [ASM_MEM_DATA_SIZE-1:0]    ext_wdata_i,
   output logic [ASM_MEM_DATA_SIZE-1:0]    ext_rdata_o,
   output logic                            ext_rvalid_o,
   output logic                            ext_stall_o,
   output logic                            sram_en_o,
   output logic [ASM_MEM_DATA_SIZE/8-1:0]  sram_we_o,
   output logic [SRAM_ADDR_SIZE-1:0]       sram_addr_o,
   output logic [ASM_MEM_DATA_SIZE-1:0]    sram_wdata_o,
   input  logic [ASM_MEM_DATA_SIZE-1:0]    sram_rdata_i,
   output logic                            err_o
);

   // Pick one 32-bit lane out of a 128-bit SRAM word
   function automatic logic [31:0] lane_sel(input logic [127:0] word, input logic [1:0] lane);
      logic [31:0] r;
      case (lane)
         2'd0:    r = word[31:0];
         2'd1:    r = word[63:32];
         2'd2:    r = word[95:64];
         default: r = word[127:96];
      endcase
      return r;
   endfunction

   logic        force_pico_s;
   logic        ext_gnt_s;
   logic        pico_gnt_s;
   logic        ext_oor_s;
   logic        pico_oor_s;
   logic        ext_is_rd_s;
   logic        pico_is_rd_s;
   logic        pico_new_s;
   logic        ext_new_s;
   logic        unused_s;

   logic        rd_valid_r;
   logic        rd_owner_r;      // 1 = external port owns the read in flight
   logic        rd_oor_r;
   logic [1:0]  rd_lane_r;
   logic        err_r;
   logic [31:0] pico_hold_r;
   logic [ASM_MEM_DATA_SIZE-1:0] ext_hold_r;

   assign unused_s = ^{pico_addr_i[1:0], ext_addr_i[3:0]};

`ifdef PICO_MEM_ARB_FAIR_EN
   localparam int unsigned             CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]        STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]        CNT_ZERO   = CNT_W'(0);
   logic [CNT_W-1:0] starve_cnt_r;

   // Count consecutive core stall cycles; any accept or idle core restarts the count
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         starve_cnt_r <= CNT_ZERO;
      end else if (pico_stall_o) begin
         starve_cnt_r <= starve_cnt_r + CNT_ONE;
      end else begin
         starve_cnt_r <= CNT_ZERO;
      end
   end

   assign force_pico_s = pico_en_i & (starve_cnt_r == STARVE_MAX);
`else
   assign force_pico_s = 1'b0;
`endif

   // External port wins a conflict unless the core has been starved long enough
   assign ext_gnt_s    = ext_en_i & ~force_pico_s;
   assign pico_gnt_s   = pico_en_i & ~ext_gnt_s;
   assign ext_stall_o  = ext_en_i & ~ext_gnt_s;
   assign pico_stall_o = pico_en_i & ~pico_gnt_s;

   assign ext_oor_s    = (ext_addr_i >= MEM_SIZE_BYTES);
   assign pico_oor_s   = (pico_addr_i >= MEM_SIZE_BYTES);
   assign ext_is_rd_s  = (ext_we_i == 16'h0000);
   assign pico_is_rd_s = (pico_we_i == 4'b0000);

   // Route the granted, in-range request onto the SRAM port
   always_comb begin
      sram_en_o    = 1'b0;
      sram_we_o    = 16'h0000;
      sram_addr_o  = 12'h000;
      sram_wdata_o = 128'h0;
      if (ext_gnt_s && !ext_oor_s) begin
         sram_en_o    = 1'b1;
         sram_we_o    = ext_we_i;
         sram_addr_o  = ext_addr_i[SRAM_ADDR_SIZE+3:4];
         sram_wdata_o = ext_wdata_i;
      end else if (pico_gnt_s && !pico_oor_s) begin
         sram_en_o    = 1'b1;
         sram_we_o    = {12'h000, pico_we_i} << {pico_addr_i[3:2], 2'b00};
         sram_addr_o  = pico_addr_i[SRAM_ADDR_SIZE+3:4];
         sram_wdata_o = {4{pico_wdata_i}};
      end else begin
         sram_en_o    = 1'b0;
         sram_we_o    = 16'h0000;
         sram_addr_o  = 12'h000;
         sram_wdata_o = 128'h0;
      end
   end

   // Remember the single read in flight, its owner and lane, and flag range errors
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         rd_valid_r <= 1'b0;
         rd_owner_r <= 1'b0;
         rd_oor_r   <= 1'b0;
         rd_lane_r  <= 2'b00;
         err_r      <= 1'b0;
      end else begin
         rd_valid_r <= (ext_gnt_s & ext_is_rd_s) | (pico_gnt_s & pico_is_rd_s);
         rd_owner_r <= ext_gnt_s;
         rd_oor_r   <= ext_gnt_s ? ext_oor_s : pico_oor_s;
         rd_lane_r  <= pico_addr_i[3:2];
         err_r      <= (ext_gnt_s & ext_oor_s) | (pico_gnt_s & pico_oor_s);
      end
   end

   assign pico_new_s = rd_valid_r & ~rd_owner_r;
   assign ext_new_s  = rd_valid_r & rd_owner_r;

   // Return fresh read data in the cycle after accept; out-of-range reads return zero
   always_comb begin
      pico_rdata_o = pico_hold_r;
      ext_rdata_o  = ext_hold_r;
      if (pico_new_s) begin
         pico_rdata_o = rd_oor_r ? 32'h0 : lane_sel(sram_rdata_i, rd_lane_r);
      end else begin
         pico_rdata_o = pico_hold_r;
      end
      if (ext_new_s) begin
         ext_rdata_o = rd_oor_r ? 128'h0 : sram_rdata_i;
      end else begin
         ext_rdata_o = ext_hold_r;
      end
   end

   // Capture returned data so both ports keep showing their last read
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         pico_hold_r <= 32'h0;
         ext_hold_r  <= 128'h0;
      end else begin
         pico_hold_r <= pico_rdata_o;
         ext_hold_r  <= ext_rdata_o;
      end
   end

   assign ext_rvalid_o = ext_new_s;
   assign err_o        = err_r;

endmodule
